// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU fetch and data channels.
// One transaction in flight at a time; data wins ties, bounded by a starvation limit for fetch.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] inst_addr,
    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    input  logic        inst_rready,

    input  logic [31:0] data_addr,
    input  logic        data_ren,
    input  logic        data_wen,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_req_ready,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    input  logic        data_rready,

    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_req_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_rready,

    output logic [31:0] conflict_cnt
);

    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_I,
        S_RESP_I,
        S_REQ_D,
        S_RESP_D
    } state_t;

    state_t      r_state;
    logic        r_op_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [3:0]  r_starve_cnt;
    logic [31:0] r_conflict_cnt;

    logic w_data_req;
    logic w_idle;
    logic w_grant_d;
    logic w_grant_i;

    assign w_data_req = data_ren | data_wen;
    // Grants are gated by rst so no handshake can complete while the arbiter is being cleared.
    assign w_idle     = (r_state == S_IDLE) & ~rst;
    assign w_grant_d  = w_idle & w_data_req &
                        (~inst_req_valid | (r_starve_cnt < LP_STARVE_LIMIT));
    assign w_grant_i  = w_idle & inst_req_valid & ~w_grant_d;

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state        <= S_IDLE;
            r_op_write     <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_starve_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_idle & inst_req_valid & w_data_req)
                r_conflict_cnt <= r_conflict_cnt + 32'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_addr     <= data_addr;
                        r_wdata    <= data_wdata;
                        r_wstrb    <= data_wstrb;
                        // A simultaneous load+store is illegal; the store wins.
                        r_op_write <= data_wen;
                        r_state    <= S_REQ_D;
                        if (inst_req_valid && (r_starve_cnt < LP_STARVE_LIMIT))
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end else if (w_grant_i) begin
                        r_addr       <= inst_addr;
                        r_wdata      <= '0;
                        r_wstrb      <= '0;
                        r_op_write   <= 1'b0;
                        r_state      <= S_REQ_I;
                        r_starve_cnt <= '0;
                    end
                end
                S_REQ_I: begin
                    if (mem_req_ready)
                        r_state <= S_RESP_I;
                end
                S_REQ_D: begin
                    if (mem_req_ready)
                        r_state <= r_op_write ? S_IDLE : S_RESP_D;
                end
                S_RESP_I: begin
                    if (mem_rvalid && inst_rready)
                        r_state <= S_IDLE;
                end
                S_RESP_D: begin
                    if (mem_rvalid && data_rready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inst_req_ready = w_grant_i;
    assign data_req_ready = w_grant_d;

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign mem_read  = ~rst & ((r_state == S_REQ_I) | ((r_state == S_REQ_D) & ~r_op_write));
    assign mem_write = ~rst & (r_state == S_REQ_D) & r_op_write;

    // Response phase is a pure pass-through steered by the current owner.
    assign mem_rready  = ~rst & (((r_state == S_RESP_I) & inst_rready) |
                                 ((r_state == S_RESP_D) & data_rready));
    assign inst_rvalid = ~rst & (r_state == S_RESP_I) & mem_rvalid;
    assign data_rvalid = ~rst & (r_state == S_RESP_D) & mem_rvalid;
    assign inst_rdata  = mem_rdata;
    assign data_rdata  = mem_rdata;

    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues expected grant/request/response events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic        inst_rready;
    logic [31:0] data_addr;
    logic        data_ren;
    logic        data_wen;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_req_ready;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        data_rready;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] conflict_cnt;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
        .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ready(data_req_ready),
        .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rready(data_rready),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [2:0] {EV_GNT_I, EV_GNT_D, EV_MREQ, EV_RESP_I, EV_RESP_D} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk(input ev_kind_t k, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        ev_t e;
        e.kind = k; e.wr = wr; e.addr = a; e.data = d; e.strb = s;
        return e;
    endfunction

    task automatic push(input ev_t e);
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_t act);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual_kind=%0d required=none t=%0t", act.kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 32'(act.kind), 32'(e.kind));
            if (e.kind == EV_MREQ) begin
                check("mreq_addr", act.addr, e.addr);
                check("mreq_wdata", act.data, e.data);
                check("mreq_wstrb", 32'(act.strb), 32'(e.strb));
                check("mreq_write", 32'(act.wr), 32'(e.wr));
            end else if (e.kind == EV_RESP_I || e.kind == EV_RESP_D) begin
                check("resp_data", act.data, e.data);
            end
        end
    endtask

    // Monitor: every handshake the DUT completes must match the next queued expectation.
    always @(negedge clk) begin
        if (data_req_ready)
            observe(mk(EV_GNT_D, 1'b0, 32'h0, 32'h0, 4'h0));
        if (inst_req_ready)
            observe(mk(EV_GNT_I, 1'b0, 32'h0, 32'h0, 4'h0));
        if ((mem_read || mem_write) && mem_req_ready)
            observe(mk(EV_MREQ, mem_write, mem_addr, mem_wdata, mem_wstrb));
        if (inst_rvalid && inst_rready)
            observe(mk(EV_RESP_I, 1'b0, 32'h0, inst_rdata, 4'h0));
        if (data_rvalid && data_rready)
            observe(mk(EV_RESP_D, 1'b0, 32'h0, data_rdata, 4'h0));
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic all_idle_outputs(input string tag);
        check({tag, "_inst_req_ready"}, 32'(inst_req_ready), 32'd0);
        check({tag, "_data_req_ready"}, 32'(data_req_ready), 32'd0);
        check({tag, "_inst_rvalid"}, 32'(inst_rvalid), 32'd0);
        check({tag, "_data_rvalid"}, 32'(data_rvalid), 32'd0);
        check({tag, "_mem_rready"}, 32'(mem_rready), 32'd0);
        check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_conflict_cnt"}, conflict_cnt, 32'd0);
        check({tag, "_starve_cnt"}, 32'(dut.r_starve_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        inst_addr = 32'h0;  inst_req_valid = 1'b1; inst_rready = 1'b0;
        data_addr = 32'h0;  data_ren = 1'b1; data_wen = 1'b0;
        data_wdata = 32'h0; data_wstrb = 4'h0; data_rready = 1'b0;
        mem_req_ready = 1'b0; mem_rdata = 32'h0; mem_rvalid = 1'b0;

        // Reset with both requesters pending: nothing granted, nothing counted.
        next(); next();
        @(negedge clk);
        all_idle_outputs("reset");

        next();
        rst = 1'b0; inst_req_valid = 1'b0; data_ren = 1'b0;
        inst_rready = 1'b1; data_rready = 1'b1; mem_req_ready = 1'b1;
        @(negedge clk);
        check("post_reset_conflict", conflict_cnt, 32'd0);

        // Lone fetch at 0x100.
        next();
        inst_addr = 32'h100; inst_req_valid = 1'b1;
        push(mk(EV_GNT_I, 1'b0, 32'h0, 32'h0, 4'h0));
        push(mk(EV_MREQ, 1'b0, 32'h100, 32'h0, 4'h0));
        push(mk(EV_RESP_I, 1'b0, 32'h0, 32'h0000_0013, 4'h0));
        @(negedge clk);
        check("fetch_grant", 32'(inst_req_ready), 32'd1);
        next();
        inst_req_valid = 1'b0;
        @(negedge clk);
        check("fetch_mem_read", 32'(mem_read), 32'd1);
        next();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        check("fetch_rvalid", 32'(inst_rvalid), 32'd1);
        check("fetch_non_owner_rvalid", 32'(data_rvalid), 32'd0);
        next();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("fetch_done_mem_read", 32'(mem_read), 32'd0);

        // Simultaneous load and fetch: data first, fetch in the next IDLE.
        next();
        data_addr = 32'h200; data_ren = 1'b1; inst_addr = 32'h104; inst_req_valid = 1'b1;
        push(mk(EV_GNT_D, 1'b0, 32'h0, 32'h0, 4'h0));
        push(mk(EV_MREQ, 1'b0, 32'h200, 32'h0, 4'h0));
        push(mk(EV_RESP_D, 1'b0, 32'h0, 32'hCAFE_0001, 4'h0));
        push(mk(EV_GNT_I, 1'b0, 32'h0, 32'h0, 4'h0));
        push(mk(EV_MREQ, 1'b0, 32'h104, 32'h0, 4'h0));
        push(mk(EV_RESP_I, 1'b0, 32'h0, 32'h0000_0093, 4'h0));
        @(negedge clk);
        next();
        data_ren = 1'b0;
        @(negedge clk);
        check("conflict_after_tie", conflict_cnt, 32'd1);
        check("no_inst_grant_outside_idle", 32'(inst_req_ready), 32'd0);
        next();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        check("load_non_owner_rvalid", 32'(inst_rvalid), 32'd0);
        next();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("conflict_held", conflict_cnt, 32'd1);
        next();
        inst_req_valid = 1'b0;
        @(negedge clk);
        check("starve_cleared_by_inst", 32'(dut.r_starve_cnt), 32'd0);
        next();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0093;
        @(negedge clk);
        next();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Store with downstream stall for 3 cycles.
        data_addr = 32'h300; data_wen = 1'b1; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
        mem_req_ready = 1'b0;
        push(mk(EV_GNT_D, 1'b0, 32'h0, 32'h0, 4'h0));
        push(mk(EV_MREQ, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011));
        @(negedge clk);
        next();
        data_wen = 1'b0; data_wdata = 32'h0; data_wstrb = 4'h0; data_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_mem_write", 32'(mem_write), 32'd1);
            check("stall_mem_read", 32'(mem_read), 32'd0);
            check("stall_mem_addr", mem_addr, 32'h300);
            check("stall_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("stall_mem_wstrb", 32'(mem_wstrb), 32'h3);
            next();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        next();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("store_no_resp_phase", 32'(data_rvalid), 32'd0);
        check("store_idle_mem_write", 32'(mem_write), 32'd0);
        next();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Load+store together is treated as a store.
        data_addr = 32'h380; data_ren = 1'b1; data_wen = 1'b1;
        data_wdata = 32'h0000_00A5; data_wstrb = 4'hF;
        push(mk(EV_GNT_D, 1'b0, 32'h0, 32'h0, 4'h0));
        push(mk(EV_MREQ, 1'b1, 32'h380, 32'h0000_00A5, 4'hF));
        @(negedge clk);
        next();
        data_ren = 1'b0; data_wen = 1'b0; data_wdata = 32'h0; data_wstrb = 4'h0;
        @(negedge clk);
        check("rw_as_write", 32'(mem_write), 32'd1);
        next();
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("rw_no_resp_phase", 32'(data_rvalid), 32'd0);
        next();
        mem_rvalid = 1'b0;

        // Continuous loads with fetch pending: 4 data grants, then fetch.
        for (int c = 0; c < 15; c++) begin
            data_addr = 32'h500; data_ren = 1'b1;
            inst_addr = 32'h400; inst_req_valid = (c < 13);
            mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 | 32'(c);
            if (c == 0 || c == 3 || c == 6 || c == 9) begin
                push(mk(EV_GNT_D, 1'b0, 32'h0, 32'h0, 4'h0));
                push(mk(EV_MREQ, 1'b0, 32'h500, 32'h0, 4'h0));
                push(mk(EV_RESP_D, 1'b0, 32'h0, 32'hA000_0000 | 32'(c + 2), 4'h0));
            end
            if (c == 12) begin
                push(mk(EV_GNT_I, 1'b0, 32'h0, 32'h0, 4'h0));
                push(mk(EV_MREQ, 1'b0, 32'h400, 32'h0, 4'h0));
                push(mk(EV_RESP_I, 1'b0, 32'h0, 32'hA000_000E, 4'h0));
            end
            @(negedge clk);
            if (c == 12)
                check("starve_saturated", 32'(dut.r_starve_cnt), 32'd4);
            if (c == 13)
                check("starve_reset_on_inst", 32'(dut.r_starve_cnt), 32'd0);
            next();
        end
        data_ren = 1'b0; inst_req_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("conflict_after_starve", conflict_cnt, 32'd6);

        // Load with data-side backpressure on the response.
        next();
        data_addr = 32'h600; data_ren = 1'b1; data_rready = 1'b0;
        push(mk(EV_GNT_D, 1'b0, 32'h0, 32'h0, 4'h0));
        push(mk(EV_MREQ, 1'b0, 32'h600, 32'h0, 4'h0));
        push(mk(EV_RESP_D, 1'b0, 32'h0, 32'h1234_5678, 4'h0));
        @(negedge clk);
        next();
        data_ren = 1'b0;
        @(negedge clk);
        next();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_mem_rready", 32'(mem_rready), 32'd0);
            check("bp_data_rvalid", 32'(data_rvalid), 32'd1);
            check("bp_data_rdata", data_rdata, 32'h1234_5678);
            next();
        end
        data_rready = 1'b1;
        @(negedge clk);
        check("bp_release_mem_rready", 32'(mem_rready), 32'd1);
        next();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("bp_done_rvalid", 32'(data_rvalid), 32'd0);

        // Reset while waiting in the load response phase.
        next();
        data_addr = 32'h700; data_ren = 1'b1; inst_addr = 32'h800; inst_req_valid = 1'b1;
        push(mk(EV_GNT_D, 1'b0, 32'h0, 32'h0, 4'h0));
        push(mk(EV_MREQ, 1'b0, 32'h700, 32'h0, 4'h0));
        @(negedge clk);
        next();
        data_ren = 1'b0; inst_req_valid = 1'b0;
        @(negedge clk);
        next();
        rst = 1'b1;
        @(negedge clk);
        check("pre_reset_conflict", conflict_cnt, 32'd7);
        check("pre_reset_starve", 32'(dut.r_starve_cnt), 32'd1);
        next();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
        @(negedge clk);
        all_idle_outputs("mid_reset");
        next();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
